// File: rtl/ras_retire_pkg.sv
// Shared return-address-stack definitions.
// Holds the default stack geometry, the RAS operation encoding that decode, the ROB and
// both stacks agree on, and the restore beat record carried towards the fetch RAS.
package ras_retire_pkg;

  localparam int unsigned RAS_SIZE  = 32;  // power of 2; head/rd_ptr wrap naturally
  localparam int unsigned RAS_IDX_W = $clog2(RAS_SIZE);
  localparam int unsigned XLEN      = 32;

  // Decode classifies JAL/JALR into these by whether rd/rs1 are link registers (x1/x5).
  typedef enum logic [1:0] {
    RAS_NONE    = 2'b00,
    RAS_PUSH    = 2'b01,
    RAS_POP     = 2'b10,
    RAS_POPPUSH = 2'b11
  } ras_op_e;

  typedef struct packed {
    logic                 valid;
    logic [RAS_IDX_W-1:0] idx;
    logic [XLEN-1:0]      rpc;
  } ras_restore_packet_t;

  function automatic logic is_link_reg(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

endpackage

// File: rtl/ras_retire_if.sv
// Restore channel from the committed RAS to the fetch-stage speculative RAS.
// master (ras_retire): restore_valid/idx/rpc beats, restore_done pulse with head/count.
// slave (fetch RAS):   restore_ready back-pressure.
interface ras_retire_if #(
  parameter int unsigned RAS_SIZE = ras_retire_pkg::RAS_SIZE,
  parameter int unsigned XLEN     = ras_retire_pkg::XLEN
);

  localparam int unsigned IdxW = $clog2(RAS_SIZE);

  logic            restore_valid;
  logic            restore_ready;
  logic [IdxW-1:0] restore_idx;
  logic [XLEN-1:0] restore_rpc;
  logic            restore_done;
  logic [IdxW-1:0] restore_head;
  logic [IdxW:0]   restore_count;

  modport master (
    output restore_valid, restore_idx, restore_rpc, restore_done, restore_head,
           restore_count,
    input  restore_ready
  );

  modport slave (
    input  restore_valid, restore_idx, restore_rpc, restore_done, restore_head,
           restore_count,
    output restore_ready
  );

endinterface

// File: rtl/ras_retire_update.sv
// Combinational retire-side update of the committed RAS.
// Applies the retire slots in order (slot 0 oldest) as if one after another, giving the
// next head/count plus one write port per slot. When two slots write the same index the
// caller must let the higher slot win.
// Ports: head/count (current), retire_valid/op/rpc (per slot), head_next/count_next,
//        wr_en/wr_idx/wr_data (per slot).
module ras_retire_update #(
  parameter int unsigned WIDTH    = 2,
  parameter int unsigned RAS_SIZE = 32,
  parameter int unsigned XLEN     = 32,
  localparam int unsigned IdxW    = $clog2(RAS_SIZE)
) (
  input  logic [IdxW-1:0]             head,
  input  logic [IdxW:0]               count,
  input  logic [WIDTH-1:0]            retire_valid,
  input  logic [WIDTH-1:0][1:0]       retire_op,
  input  logic [WIDTH-1:0][XLEN-1:0]  retire_rpc,
  output logic [IdxW-1:0]             head_next,
  output logic [IdxW:0]               count_next,
  output logic [WIDTH-1:0]            wr_en,
  output logic [WIDTH-1:0][IdxW-1:0]  wr_idx,
  output logic [WIDTH-1:0][XLEN-1:0]  wr_data
);
  import ras_retire_pkg::*;

  localparam logic [IdxW:0] CountFull = RAS_SIZE[IdxW:0];

  logic [IdxW-1:0] h;
  logic [IdxW:0]   c;
  logic            do_push;

  always_comb begin
    h       = head;
    c       = count;
    wr_en   = '0;
    wr_idx  = '0;
    wr_data = retire_rpc;
    do_push = 1'b0;
    for (int s = 0; s < WIDTH; s++) begin
      do_push = 1'b0;
      if (retire_valid[s]) begin
        unique case (ras_op_e'(retire_op[s]))
          RAS_NONE: ;
          RAS_PUSH: do_push = 1'b1;
          RAS_POP: begin
            if (c != '0) begin
              h = h - 1'b1;
              c = c - 1'b1;
            end
          end
          RAS_POPPUSH: begin
            // Replace the top in place; on an empty stack it degenerates to a push.
            if (c != '0) begin
              wr_en[s]  = 1'b1;
              wr_idx[s] = h - 1'b1;
            end else begin
              do_push = 1'b1;
            end
          end
        endcase
      end
      if (do_push) begin
        // When full, head wraps onto the oldest entry and overwrites it.
        wr_en[s]  = 1'b1;
        wr_idx[s] = h;
        h         = h + 1'b1;
        if (c != CountFull) c = c + 1'b1;
      end
    end
    head_next  = h;
    count_next = c;
  end

endmodule

// File: rtl/ras_retire.sv
// Committed (architectural) return address stack.
// Updated from the ROB retire slots while idle. On rollback it replays its committed
// entries oldest-first to the fetch RAS over a valid/ready channel, then pulses
// restore_done with the committed head/count.
// Ports: clock, reset (sync, active-high); retire_valid/op/rpc per slot; rollback_en;
//        restore (ras_retire_if master); busy (fetch must stall its RAS while high).
module ras_retire #(
  parameter int unsigned WIDTH    = 2,
  parameter int unsigned RAS_SIZE = ras_retire_pkg::RAS_SIZE,
  parameter int unsigned XLEN     = ras_retire_pkg::XLEN
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           retire_valid,
  input  logic [WIDTH-1:0][1:0]      retire_op,
  input  logic [WIDTH-1:0][XLEN-1:0] retire_rpc,
  input  logic                       rollback_en,
  ras_retire_if.master               restore,
  output logic                       busy
);
  import ras_retire_pkg::*;

  localparam int unsigned IdxW = $clog2(RAS_SIZE);

  typedef enum logic [1:0] {StIdle, StRestore, StDone} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] stack_q [RAS_SIZE];
  logic [IdxW-1:0] head_q, head_d;
  logic [IdxW:0]   count_q, count_d;
  logic [IdxW-1:0] rd_ptr_q, rd_ptr_d;
  logic [IdxW:0]   remaining_q, remaining_d;

  logic [IdxW-1:0]             upd_head;
  logic [IdxW:0]               upd_count;
  logic [WIDTH-1:0]            upd_we;
  logic [WIDTH-1:0][IdxW-1:0]  upd_idx;
  logic [WIDTH-1:0][XLEN-1:0]  upd_data;
  logic [WIDTH-1:0]            stack_we;

  logic            restore_valid;
  logic            beat_fire;
  logic [IdxW-1:0] reload_head;
  logic [IdxW:0]   reload_count;

  ras_retire_update #(
    .WIDTH    (WIDTH),
    .RAS_SIZE (RAS_SIZE),
    .XLEN     (XLEN)
  ) u_update (
    .head         (head_q),
    .count        (count_q),
    .retire_valid (retire_valid),
    .retire_op    (retire_op),
    .retire_rpc   (retire_rpc),
    .head_next    (upd_head),
    .count_next   (upd_count),
    .wr_en        (upd_we),
    .wr_idx       (upd_idx),
    .wr_data      (upd_data)
  );

  assign restore_valid = (state_q == StRestore);
  assign beat_fire     = restore_valid && restore.restore_ready;

  // Idle rollbacks see this cycle's retirements; while busy retirements are ignored.
  assign reload_head  = (state_q == StIdle) ? upd_head  : head_q;
  assign reload_count = (state_q == StIdle) ? upd_count : count_q;

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    stack_we    = '0;
    if (state_q == StIdle) begin
      head_d   = upd_head;
      count_d  = upd_count;
      stack_we = upd_we;
    end
    if (rollback_en) begin
      // Any rollback (including one mid-restore) starts again from the oldest entry.
      rd_ptr_d    = reload_head - reload_count[IdxW-1:0];
      remaining_d = reload_count;
      state_d     = (reload_count == '0) ? StDone : StRestore;
    end else begin
      unique case (state_q)
        StIdle: ;
        StRestore: begin
          if (beat_fire) begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
            if (remaining_q == (IdxW+1)'(1)) state_d = StDone;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      head_q      <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      remaining_q <= remaining_d;
    end
  end

  // Slots are written in ascending order so the younger slot wins on a shared index.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < RAS_SIZE; i++) stack_q[i] <= '0;
    end else begin
      for (int s = 0; s < WIDTH; s++) begin
        if (stack_we[s]) stack_q[upd_idx[s]] <= upd_data[s];
      end
    end
  end

  always_comb begin
    restore.restore_valid = restore_valid;
    restore.restore_idx   = restore_valid ? rd_ptr_q : '0;
    restore.restore_rpc   = restore_valid ? stack_q[rd_ptr_q] : '0;
    restore.restore_done  = (state_q == StDone);
    restore.restore_head  = (state_q == StDone) ? head_q : '0;
    restore.restore_count = (state_q == StDone) ? count_q : '0;
    busy                  = (state_q != StIdle);
  end

endmodule

// File: tb/tb_ras_retire.sv
module tb_ras_retire;
  import ras_retire_pkg::*;

  localparam int unsigned W = 2;
  localparam int unsigned N = 32;
  localparam int unsigned X = 32;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [1:0]          retire_valid;
  logic [1:0][1:0]     retire_op;
  logic [1:0][31:0]    retire_rpc;
  logic                rollback_en;
  logic                busy;

  always #5 clock = ~clock;

  ras_retire_if #(.RAS_SIZE(N), .XLEN(X)) rif ();

  ras_retire #(.WIDTH(W), .RAS_SIZE(N), .XLEN(X)) dut (
    .clock        (clock),
    .reset        (reset),
    .retire_valid (retire_valid),
    .retire_op    (retire_op),
    .retire_rpc   (retire_rpc),
    .rollback_en  (rollback_en),
    .restore      (rif),
    .busy         (busy)
  );

  typedef struct packed {logic [4:0] idx; logic [31:0] rpc;} beat_t;
  typedef struct packed {logic [4:0] head; logic [5:0] count;} done_t;

  typedef struct {
    bit         rst;
    logic [1:0] rv;
    logic [1:0] op0;
    logic [1:0] op1;
    logic [31:0] r0;
    logic [31:0] r1;
    bit         rb;
    logic [4:0] eh;
    logic [5:0] ec;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model and scoreboard
  logic [31:0] m_stack [N];
  logic [4:0]  m_head;
  int          m_count;
  beat_t       beat_q[$];
  done_t       done_q[$];
  beat_t       mon_beat;
  done_t       mon_done;
  int          done_seen = 0;
  logic [4:0]  last_idx;
  logic [31:0] last_rpc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_stack[i] = '0;
    m_head = '0;
    m_count = 0;
    beat_q.delete();
    done_q.delete();
  endtask

  task automatic model_push(input logic [31:0] r);
    m_stack[m_head] = r;
    m_head = m_head + 5'd1;
    if (m_count < N) m_count++;
  endtask

  task automatic model_op(input logic [1:0] op, input logic [31:0] r);
    case (op)
      2'b01: model_push(r);
      2'b10: if (m_count > 0) begin m_head = m_head - 5'd1; m_count--; end
      2'b11: if (m_count > 0) m_stack[m_head - 5'd1] = r; else model_push(r);
      default: ;
    endcase
  endtask

  task automatic model_rollback(input bit restart);
    beat_t b;
    done_t d;
    if (restart) begin
      beat_q.delete();
      done_q.delete();
    end
    for (int k = 0; k < m_count; k++) begin
      b.idx = m_head - 5'(m_count) + 5'(k);
      b.rpc = m_stack[b.idx];
      beat_q.push_back(b);
    end
    d.head  = m_head;
    d.count = 6'(m_count);
    done_q.push_back(d);
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic step(input logic [1:0] rv, input logic [1:0] op0, input logic [1:0] op1,
                      input logic [31:0] r0, input logic [31:0] r1, input bit rb);
    @(posedge clock); #1;
    retire_valid  = rv;
    retire_op[0]  = op0;
    retire_op[1]  = op1;
    retire_rpc[0] = r0;
    retire_rpc[1] = r1;
    rollback_en   = rb;
    if (rv[0]) model_op(op0, r0);
    if (rv[1]) model_op(op1, r1);
    if (rb) model_rollback(1'b0);
    @(posedge clock); #1;
    retire_valid = '0;
    retire_op    = '0;
    retire_rpc   = '0;
    rollback_en  = 1'b0;
  endtask

  task automatic expect_done(input string name, input logic [4:0] eh, input logic [5:0] ec,
                             input int eb);
    int         bc;
    logic [4:0] h;
    logic [5:0] c;
    bit         ok;
    bc = 0; ok = 1'b0; h = '0; c = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (busy) bc++;
      if (rif.restore_done) begin
        ok = 1'b1;
        h  = rif.restore_head;
        c  = rif.restore_count;
        break;
      end
    end
    check({name, "_done_seen"}, 64'(ok), 64'd1);
    if (ok) begin
      check({name, "_done_head"}, 64'(h), 64'(eh));
      check({name, "_done_count"}, 64'(c), 64'(ec));
      check({name, "_busy_cycles"}, 64'(bc), 64'(eb));
      @(negedge clock);
      check({name, "_busy_low_after"}, 64'(busy), 64'd0);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_valid"}, 64'(rif.restore_valid), 64'd0);
    check({name, "_idx"},   64'(rif.restore_idx),   64'd0);
    check({name, "_rpc"},   64'(rif.restore_rpc),   64'd0);
    check({name, "_done"},  64'(rif.restore_done),  64'd0);
    check({name, "_head"},  64'(rif.restore_head),  64'd0);
    check({name, "_count"}, 64'(rif.restore_count), 64'd0);
    check({name, "_busy"},  64'(busy),              64'd0);
  endtask

  // Monitor: compares every transferred beat and every done pulse against the scoreboard.
  always @(negedge clock) begin
    if (!reset) begin
      if (busy) begin
        n_checks++;
        if (retire_valid != '0) begin
          n_errors++;
          $display("FAIL retire_while_busy: got retire_valid=%b, expected 00", retire_valid);
        end
      end
      if (rif.restore_valid && rif.restore_ready) begin
        if (beat_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_beat: got idx=%0d rpc=0x%0h, expected no beat",
                   rif.restore_idx, rif.restore_rpc);
        end else begin
          mon_beat = beat_q.pop_front();
          check("beat_idx", 64'(rif.restore_idx), 64'(mon_beat.idx));
          check("beat_rpc", 64'(rif.restore_rpc), 64'(mon_beat.rpc));
        end
        last_idx = rif.restore_idx;
        last_rpc = rif.restore_rpc;
      end
      if (rif.restore_done) begin
        done_seen++;
        if (done_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got head=%0d count=%0d, expected no done",
                   rif.restore_head, rif.restore_count);
        end else begin
          mon_done = done_q.pop_front();
          check("sb_done_head", 64'(rif.restore_head), 64'(mon_done.head));
          check("sb_done_count", 64'(rif.restore_count), 64'(mon_done.count));
          check("sb_beats_pending_at_done", 64'(beat_q.size()), 64'd0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected self-termination");
    $fatal(1);
  end

  vec_t vecs[11];
  int   ds;

  initial begin
    retire_valid = '0;
    retire_op    = '0;
    retire_rpc   = '0;
    rollback_en  = 1'b0;
    rif.restore_ready = 1'b1;
    model_reset();

    vecs[0]  = '{1, 2'b11, RAS_PUSH,    RAS_POP,     32'h300, 32'h0,  1, 5'd0, 6'd0};
    vecs[1]  = '{1, 2'b01, RAS_POP,     RAS_NONE,    32'h0,   32'h0,  0, 5'd0, 6'd0};
    vecs[2]  = '{0, 2'b01, RAS_POPPUSH, RAS_NONE,    32'h500, 32'h0,  1, 5'd1, 6'd1};
    vecs[3]  = '{1, 2'b11, RAS_PUSH,    RAS_PUSH,    32'h10,  32'h14, 0, 5'd0, 6'd0};
    vecs[4]  = '{0, 2'b11, RAS_POPPUSH, RAS_POPPUSH, 32'h18,  32'h1c, 0, 5'd0, 6'd0};
    vecs[5]  = '{0, 2'b11, RAS_POP,     RAS_PUSH,    32'h0,   32'h20, 1, 5'd2, 6'd2};
    vecs[6]  = '{0, 2'b10, RAS_PUSH,    RAS_PUSH,    32'h99,  32'h24, 0, 5'd0, 6'd0};
    vecs[7]  = '{0, 2'b11, RAS_NONE,    RAS_POP,     32'h0,   32'h0,  1, 5'd2, 6'd2};
    vecs[8]  = '{0, 2'b11, RAS_POP,     RAS_POP,     32'h0,   32'h0,  1, 5'd0, 6'd0};
    vecs[9]  = '{0, 2'b11, RAS_PUSH,    RAS_POPPUSH, 32'h30,  32'h34, 1, 5'd1, 6'd1};
    vecs[10] = '{0, 2'b11, RAS_POP,     RAS_POP,     32'h0,   32'h0,  1, 5'd0, 6'd0};

    do_reset();
    @(negedge clock);
    check_idle_outputs("reset");

    // Two pushes then a rollback: two beats and a done, busy for three cycles.
    step(2'b01, RAS_PUSH, RAS_NONE, 32'h104, 32'h0, 1'b0);
    step(2'b01, RAS_PUSH, RAS_NONE, 32'h208, 32'h0, 1'b0);
    step(2'b00, RAS_NONE, RAS_NONE, 32'h0,   32'h0, 1'b1);
    expect_done("basic", 5'd2, 6'd2, 3);

    // Table-driven retire patterns, each optionally followed by a restore.
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].rst) do_reset();
      step(vecs[i].rv, vecs[i].op0, vecs[i].op1, vecs[i].r0, vecs[i].r1, vecs[i].rb);
      if (vecs[i].rb) expect_done($sformatf("vec%0d", i), vecs[i].eh, vecs[i].ec,
                                  int'(vecs[i].ec) + 1);
    end

    // Overfill: 33 pushes wrap onto the oldest entry.
    do_reset();
    for (int i = 0; i < 33; i++) step(2'b01, RAS_PUSH, RAS_NONE, 32'h1000 + 32'(4 * i), 32'h0, 1'b0);
    step(2'b00, RAS_NONE, RAS_NONE, 32'h0, 32'h0, 1'b1);
    @(negedge clock);
    check("full_first_valid", 64'(rif.restore_valid), 64'd1);
    check("full_first_idx", 64'(rif.restore_idx), 64'd1);
    check("full_first_rpc", 64'(rif.restore_rpc), 64'h1004);
    expect_done("full", 5'd1, 6'd32, 32);
    check("full_last_idx", 64'(last_idx), 64'd0);
    check("full_last_rpc", 64'(last_rpc), 64'h1080);

    // Back-pressure: beat 1 must hold while ready is low.
    do_reset();
    step(2'b11, RAS_PUSH, RAS_PUSH, 32'ha0, 32'ha4, 1'b0);
    step(2'b01, RAS_PUSH, RAS_NONE, 32'ha8, 32'h0,  1'b0);
    step(2'b00, RAS_NONE, RAS_NONE, 32'h0,  32'h0,  1'b1);
    @(negedge clock);
    @(posedge clock); #1;
    rif.restore_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      check("stall_valid", 64'(rif.restore_valid), 64'd1);
      check("stall_idx", 64'(rif.restore_idx), 64'd1);
      check("stall_rpc", 64'(rif.restore_rpc), 64'ha4);
      if (k == 0) begin @(posedge clock); #1; end
    end
    @(posedge clock); #1;
    rif.restore_ready = 1'b1;
    expect_done("stall", 5'd3, 6'd3, 3);

    // Rollback during beat 2 restarts from the oldest entry.
    do_reset();
    step(2'b11, RAS_PUSH, RAS_PUSH, 32'hb0, 32'hb4, 1'b0);
    step(2'b01, RAS_PUSH, RAS_NONE, 32'hb8, 32'h0,  1'b0);
    step(2'b00, RAS_NONE, RAS_NONE, 32'h0,  32'h0,  1'b1);
    @(negedge clock);
    @(posedge clock); #1;
    rollback_en = 1'b1;
    rif.restore_ready = 1'b0;
    model_rollback(1'b1);
    @(negedge clock);
    check("restart_beat2_idx", 64'(rif.restore_idx), 64'd1);
    @(posedge clock); #1;
    rollback_en = 1'b0;
    rif.restore_ready = 1'b1;
    @(negedge clock);
    check("restart_oldest_idx", 64'(rif.restore_idx), 64'd0);
    check("restart_oldest_rpc", 64'(rif.restore_rpc), 64'hb0);
    expect_done("restart", 5'd3, 6'd3, 3);

    // Reset during a restore aborts it with no done pulse.
    step(2'b00, RAS_NONE, RAS_NONE, 32'h0, 32'h0, 1'b1);
    @(negedge clock);
    @(posedge clock); #1;
    reset = 1'b1;
    model_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check_idle_outputs("midreset");
    ds = done_seen;
    repeat (5) @(negedge clock);
    check("midreset_no_done", 64'(done_seen), 64'(ds));
    step(2'b00, RAS_NONE, RAS_NONE, 32'h0, 32'h0, 1'b1);
    expect_done("post_reset", 5'd0, 6'd0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
